lock_request_arbiter: RTL and testbench
=======================================

Name: lock_request_arbiter

Overview:
- Sits directly upstream of the lock availability table.
- Collects acquire and release requests from NUM_THREADS threads and serialises them onto the table's single request port and single release port.
- Retries denied acquires in a deterministic round-robin order, so the grant order depends only on request arrival cycles, never on timing races.
- Returns one-cycle grant pulses to the requesting threads.

Parameters:
- NUM_THREADS, 4, number of requesting threads; power of two, range 2..16.
- LOCK_WIDTH, 2, lock id width; matches `LOCK_WIDTH.
- CNT_WIDTH, 16, width of the saturating retry counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high; all state cleared.
- acq_valid  in  NUM_THREADS  per-thread acquire request.
- acq_lock  in  NUM_THREADS*LOCK_WIDTH  per-thread requested lock id; thread i uses slice [i*LOCK_WIDTH +: LOCK_WIDTH].
- acq_ready  out  NUM_THREADS  per-thread acquire slot free (= !pend_acq[i]).
- acq_grant  out  NUM_THREADS  one-cycle grant pulse, registered.
- rel_valid  in  NUM_THREADS  per-thread release request.
- rel_lock  in  NUM_THREADS*LOCK_WIDTH  per-thread released lock id.
- rel_ready  out  NUM_THREADS  one-hot; release of thread i accepted this cycle.
- request_lock  out  1  to table: acquire attempt this cycle.
- lock_requested  out  LOCK_WIDTH  to table: lock id of the attempt.
- lock_granted  in  1  from table: same-cycle result of the attempt.
- release_lock  out  1  to table: release this cycle.
- lock_released  out  LOCK_WIDTH  to table: released lock id.
- retry_cnt  out  CNT_WIDTH  count of denied attempts; saturating.
- busy  out  1  OR of all pend_acq bits.

Behaviour:
- State:
  - pend_acq[NUM_THREADS] and pend_lock[NUM_THREADS][LOCK_WIDTH], one entry per thread.
  - Token pointer ptr, log2(NUM_THREADS) bits.
  - acq_grant register.
  - retry_cnt register.
- Reset (asynchronous): pend_acq=0, pend_lock=0, ptr=0, acq_grant=0, retry_cnt=0. Consequently acq_ready=all 1s, request_lock=0, release_lock=0, rel_ready=0, busy=0.
- Acquire capture:
  - acq_valid[i] && acq_ready[i] sets pend_acq[i]=1 and pend_lock[i]=acq_lock slice on the next edge.
  - While pend_acq[i]=1, acq_valid[i] is ignored.
- Release path (combinational, priority over acquire):
  - The chosen release is the lowest index i with rel_valid[i]=1.
  - For that i: rel_ready[i]=1, release_lock=1, lock_released=rel_lock slice i.
  - All other threads hold their release request; they are served one per cycle.
  - No state change beyond the table update.
- Acquire issue, only in cycles with no release:
  - If pend_acq[ptr]=1: request_lock=1 and lock_requested=pend_lock[ptr].
  - On lock_granted=1: clear pend_acq[ptr] and set acq_grant[ptr]=1 for exactly the next cycle.
  - On lock_granted=0: keep the entry pending and increment retry_cnt, saturating at all ones.
- Pointer advance:
  - ptr increments mod NUM_THREADS in every cycle with no release, whether or not ptr's thread was pending or granted.
  - ptr holds in release cycles.
  - Result: each thread gets an attempt slot at most once every NUM_THREADS non-release cycles; the attempt order is deterministic.
- Latency:
  - Capture edge to first possible attempt: 1 cycle minimum, NUM_THREADS cycles maximum (excluding release cycles).
  - Attempt cycle to acq_grant pulse: 1 cycle.
- Simultaneous events:
  - Capture and grant for different threads in the same cycle are independent.
  - Thread i may re-request in the cycle acq_grant[i] is high, because acq_ready[i] is already 1.
- lock_granted is ignored when request_lock=0.
- rst asserted mid-operation: all pending requests are dropped and no grant pulses are issued; threads must re-request.

Test Plan:
1. Reset, then thread 2 acquires lock 1 with the table free -> request_lock high with lock_requested=1 at ptr=2 (2 cycles after capture); acq_grant=4'b0100 for one cycle; retry_cnt=0.
2. Threads 0 and 1 both request lock 0 in the same cycle -> thread 0 granted first; thread 1 denied on each of its slots, retry_cnt incrementing by 1 per slot; after thread 0 releases lock 0, thread 1 is granted on its next slot.
3. rel_valid=4'b1010 held -> rel_ready=4'b0010, then 4'b1000 on the next cycle; ptr holds during both cycles; no request_lock in those cycles.
4. Force a retry_cnt saturation value of 16'hFFFF (preload) and cause one more denial -> retry_cnt stays 16'hFFFF.
5. Thread 3 pending and rst pulsed mid-wait -> pend cleared, busy=0, no acq_grant pulse, ptr=0 after reset.
6. Thread 0 re-requests in its grant cycle -> captured on that edge; next attempt on the next ptr=0 slot.

Source files
------------

// File: rtl/lock_request_arbiter.sv
// Serialises per-thread lock acquire/release requests onto the lock table's single
// request and release ports; denied acquires are retried on a round-robin token.

module lock_req_slot #(
    parameter int LOCK_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  acq_valid,
    input  logic [LOCK_WIDTH-1:0] acq_lock,
    input  logic                  attempt,
    input  logic                  granted,
    output logic                  pend,
    output logic [LOCK_WIDTH-1:0] pend_lock,
    output logic                  grant
);

    // attempt is only raised while pend is set, so a grant never coincides with a capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_lock <= '0;
            grant     <= 1'b0;
        end else begin
            grant <= attempt && granted;
            if (attempt && granted) begin
                pend <= 1'b0;
            end else if (acq_valid && !pend) begin
                pend      <= 1'b1;
                pend_lock <= acq_lock;
            end
        end
    end

endmodule

module lock_request_arbiter #(
    parameter int NUM_THREADS = 4,
    parameter int LOCK_WIDTH  = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_THREADS-1:0]            acq_valid,
    input  logic [NUM_THREADS*LOCK_WIDTH-1:0] acq_lock,
    output logic [NUM_THREADS-1:0]            acq_ready,
    output logic [NUM_THREADS-1:0]            acq_grant,
    input  logic [NUM_THREADS-1:0]            rel_valid,
    input  logic [NUM_THREADS*LOCK_WIDTH-1:0] rel_lock,
    output logic [NUM_THREADS-1:0]            rel_ready,
    output logic                              request_lock,
    output logic [LOCK_WIDTH-1:0]             lock_requested,
    input  logic                              lock_granted,
    output logic                              release_lock,
    output logic [LOCK_WIDTH-1:0]             lock_released,
    output logic [CNT_WIDTH-1:0]              retry_cnt,
    output logic                              busy
);

    localparam int PTR_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    typedef struct packed {
        logic                  vld;
        logic [LOCK_WIDTH-1:0] lock;
    } tbl_req_t;

    logic [NUM_THREADS-1:0][LOCK_WIDTH-1:0] acq_lock_v;
    logic [NUM_THREADS-1:0][LOCK_WIDTH-1:0] rel_lock_v;
    logic [NUM_THREADS-1:0][LOCK_WIDTH-1:0] pend_lock;
    logic [NUM_THREADS-1:0]                 pend_acq;
    logic [NUM_THREADS-1:0]                 attempt_sel;
    logic [PTR_W-1:0]                       ptr;
    tbl_req_t                               acq_req;
    tbl_req_t                               rel_req;
    logic                                   rel_any;
    logic                                   attempt_deny;

    assign acq_lock_v = acq_lock;
    assign rel_lock_v = rel_lock;
    assign rel_any    = |rel_valid;

    // Isolate the lowest set bit: that thread's release is served this cycle
    assign rel_ready = rel_valid & (~rel_valid + NUM_THREADS'(1));

    always_comb begin
        rel_req     = '0;
        rel_req.vld = rel_any;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (rel_ready[i]) rel_req.lock = rel_lock_v[i];
        end
    end

    // Releases own the cycle; the token slot only issues when no release is present
    always_comb begin
        acq_req.vld          = !rel_any && pend_acq[ptr];
        acq_req.lock         = pend_lock[ptr];
        attempt_sel          = '0;
        attempt_sel[ptr]     = acq_req.vld;
    end

    assign attempt_deny   = acq_req.vld && !lock_granted;

    assign request_lock   = acq_req.vld;
    assign lock_requested = acq_req.lock;
    assign release_lock   = rel_req.vld;
    assign lock_released  = rel_req.lock;
    assign acq_ready      = ~pend_acq;
    assign busy           = |pend_acq;

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_slot
        lock_req_slot #(.LOCK_WIDTH(LOCK_WIDTH)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .acq_valid (acq_valid[g]),
            .acq_lock  (acq_lock_v[g]),
            .attempt   (attempt_sel[g]),
            .granted   (lock_granted),
            .pend      (pend_acq[g]),
            .pend_lock (pend_lock[g]),
            .grant     (acq_grant[g])
        );
    end

    // Token advances every non-release cycle regardless of the slot's outcome
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            retry_cnt <= '0;
        end else begin
            if (!rel_any) ptr <= ptr + PTR_W'(1);
            if (attempt_deny && (retry_cnt != '1)) retry_cnt <= retry_cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_lock_request_arbiter.sv
// Directed bench for lock_request_arbiter with a behavioural lock table on the
// table ports; a second, narrow-counter instance exercises retry saturation.

module tb_lock_request_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] acq_valid, acq_ready, acq_grant, rel_valid, rel_ready;
    logic [7:0] acq_lock, rel_lock;
    logic       request_lock, lock_granted, release_lock, busy;
    logic [1:0] lock_requested, lock_released;
    logic [15:0] retry_cnt;
    logic [3:0] held;

    logic       s_rst;
    logic [1:0] s_acq_valid, s_acq_ready, s_acq_grant, s_rel_valid, s_rel_ready;
    logic [3:0] s_acq_lock, s_rel_lock;
    logic       s_request_lock, s_lock_granted, s_release_lock, s_busy;
    logic [1:0] s_lock_requested, s_lock_released, s_retry_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lock_request_arbiter #(.NUM_THREADS(4), .LOCK_WIDTH(2), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .acq_valid(acq_valid), .acq_lock(acq_lock),
        .acq_ready(acq_ready), .acq_grant(acq_grant), .rel_valid(rel_valid),
        .rel_lock(rel_lock), .rel_ready(rel_ready), .request_lock(request_lock),
        .lock_requested(lock_requested), .lock_granted(lock_granted),
        .release_lock(release_lock), .lock_released(lock_released),
        .retry_cnt(retry_cnt), .busy(busy)
    );

    lock_request_arbiter #(.NUM_THREADS(2), .LOCK_WIDTH(2), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(s_rst), .acq_valid(s_acq_valid), .acq_lock(s_acq_lock),
        .acq_ready(s_acq_ready), .acq_grant(s_acq_grant), .rel_valid(s_rel_valid),
        .rel_lock(s_rel_lock), .rel_ready(s_rel_ready), .request_lock(s_request_lock),
        .lock_requested(s_lock_requested), .lock_granted(s_lock_granted),
        .release_lock(s_release_lock), .lock_released(s_lock_released),
        .retry_cnt(s_retry_cnt), .busy(s_busy)
    );

    // Lock table: grants a free lock in the same cycle, tracks ownership across edges
    assign lock_granted = request_lock && !held[lock_requested];
    initial held = '0;
    always @(posedge clk) begin
        if (request_lock && lock_granted) held[lock_requested] <= 1'b1;
        if (release_lock) held[lock_released] <= 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; acq_valid = '0; acq_lock = '0; rel_valid = '0; rel_lock = '0;
        s_rst = 1'b1; s_acq_valid = '0; s_acq_lock = '0; s_rel_valid = '0; s_rel_lock = '0;
        s_lock_granted = 1'b0;
        repeat (2) step;
        mid;
        chk("rst_acq_ready", acq_ready, 4'b1111);
        chk("rst_request", request_lock, 0);
        chk("rst_release", release_lock, 0);
        chk("rst_rel_ready", rel_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", acq_grant, 0);
        chk("rst_retry", retry_cnt, 0);

        // 1: thread 2 acquires free lock 1
        step; rst = 1'b0; acq_valid = 4'b0100; acq_lock = 8'b00_01_00_00;      // C0
        step; acq_valid = '0;                                                  // C1
        mid;  chk("t1_no_req", request_lock, 0); chk("t1_busy", busy, 1);
              chk("t1_ready", acq_ready, 4'b1011);
        step; mid;                                                             // C2
        chk("t1_req", request_lock, 1); chk("t1_lock", lock_requested, 1);
        // 2: threads 0 and 1 contend for lock 0
        step; acq_valid = 4'b0011; acq_lock = 8'h00;                           // C3
        mid;  chk("t1_grant", acq_grant, 4'b0100); chk("t1_retry", retry_cnt, 0);
              chk("t1_idle", busy, 0);
        step; acq_valid = '0;                                                  // C4
        mid;  chk("t2_req0", request_lock, 1); chk("t2_lock0", lock_requested, 0);
              chk("t2_pulse_gone", acq_grant, 0); chk("t2_ready", acq_ready, 4'b1100);
        step; mid;                                                             // C5
        chk("t2_grant0", acq_grant, 4'b0001); chk("t2_req1", request_lock, 1);
        chk("t2_retry0", retry_cnt, 0);
        step; mid; chk("t2_retry1", retry_cnt, 1);                             // C6
        repeat (3) step;                                                       // C9
        mid;  chk("t2_req1b", request_lock, 1); chk("t2_retry1b", retry_cnt, 1);
        step; rel_valid = 4'b0001; rel_lock = 8'h00;                           // C10
        mid;  chk("t2_retry2", retry_cnt, 2); chk("t2_rel_ready", rel_ready, 4'b0001);
              chk("t2_rel", release_lock, 1); chk("t2_rel_lock", lock_released, 0);
              chk("t2_rel_noreq", request_lock, 0);
        step; rel_valid = '0;                                                  // C11
        repeat (2) step;                                                       // C13
        mid;  chk("t2_slot0_idle", request_lock, 0);
        step; mid;                                                             // C14
        chk("t2_req1c", request_lock, 1); chk("t2_lock1c", lock_requested, 0);
        // 3: two held releases drained lowest first, token frozen
        step; acq_valid = 4'b1000; acq_lock = 8'b11_00_00_00;                  // C15
        mid;  chk("t2_grant1", acq_grant, 4'b0010); chk("t2_retry_final", retry_cnt, 2);
        step; acq_valid = '0; rel_valid = 4'b1010; rel_lock = 8'b10_00_00_00;  // C16
        mid;  chk("t3_rel_a", rel_ready, 4'b0010); chk("t3_noreq_a", request_lock, 0);
              chk("t3_lock_a", lock_released, 0); chk("t3_busy", busy, 1);
        step; rel_valid = 4'b1000;                                             // C17
        mid;  chk("t3_rel_b", rel_ready, 4'b1000); chk("t3_noreq_b", request_lock, 0);
              chk("t3_lock_b", lock_released, 2);
        step; rel_valid = '0;                                                  // C18
        mid;  chk("t3_ptr_held", request_lock, 1); chk("t3_lock3", lock_requested, 3);
        // 6: thread 0 re-requests during its grant pulse
        step; acq_valid = 4'b0001; acq_lock = 8'b00_00_00_10;                  // C19
        mid;  chk("t3_grant3", acq_grant, 4'b1000);
        step; acq_valid = '0;                                                  // C20
        repeat (3) step;                                                       // C23
        mid;  chk("t6_req", request_lock, 1); chk("t6_lock", lock_requested, 2);
        step; acq_valid = 4'b0001; acq_lock = 8'b00_00_00_10;                  // C24
        mid;  chk("t6_grant", acq_grant, 4'b0001); chk("t6_ready", acq_ready, 4'b1111);
        step; acq_valid = '0;                                                  // C25
        mid;  chk("t6_captured", acq_ready, 4'b1110); chk("t6_busy", busy, 1);
        step; mid; chk("t6_wait", request_lock, 0);                            // C26
        step; mid;                                                             // C27
        chk("t6_reattempt", request_lock, 1); chk("t6_relock", lock_requested, 2);
        // 5: reset while threads 0 and 3 are pending
        step; acq_valid = 4'b1000; acq_lock = 8'h00;                           // C28
        mid;  chk("t6_retry3", retry_cnt, 3);
        step; acq_valid = '0;                                                  // C29
        mid;  chk("t5_pending", acq_ready, 4'b0110);
        rst = 1'b1; #1;
        chk("t5_busy", busy, 0); chk("t5_ready", acq_ready, 4'b1111);
        chk("t5_noreq", request_lock, 0); chk("t5_nogrant", acq_grant, 0);
        step; rst = 1'b0; acq_valid = 4'b0010; acq_lock = 8'h00;               // C30
        mid;  chk("t5_nogrant2", acq_grant, 0); chk("t5_retry", retry_cnt, 0);
              chk("t5_noreq2", request_lock, 0);
        step; acq_valid = '0;                                                  // C31
        mid;  chk("t5_ptr0", request_lock, 1); chk("t5_lock", lock_requested, 0);
        step; mid;                                                             // C32
        chk("t5_grant", acq_grant, 4'b0010); chk("t5_idle", busy, 0);

        // 4: 2-bit counter on a permanently denied thread saturates at all ones
        step; s_rst = 1'b0; s_acq_valid = 2'b01; s_acq_lock = '0;
        step;
        step; mid; chk("sat_req", s_request_lock, 1);
        step; mid; chk("sat_first", s_retry_cnt, 1);
        repeat (6) step;
        mid;  chk("sat_full", s_retry_cnt, 3);
        repeat (4) step;
        mid;  chk("sat_hold", s_retry_cnt, 3); chk("sat_busy", s_busy, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
